br_resolve_pred: RTL
====================

Name: br_resolve_pred

Overview:
- Branch predict/resolve unit for the RV32I pipeline.
- Fetch side: looks up a direction predictor (2-bit counters) plus a target buffer using the fetch PC.
- Execute side: decodes funct3 into the br_unsigned select for the branch comparator and combines the comparator's br_less/br_equal into the actual outcome.
- Detects mispredicts, trains the tables, and issues a registered one-cycle redirect/flush to fetch.

Parameters:
- IDX_W, 6, index width; table depth = 2**IDX_W entries.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_pc  in  XLEN  fetch PC for lookup.
- pred_taken  out  1  fetch prediction: taken (combinational from table state).
- pred_target  out  XLEN  predicted target; valid when pred_taken=1.
- ex_valid  in  1  EX-stage instruction valid.
- ex_stall  in  1  EX held; no resolve or update this cycle.
- ex_is_branch  in  1  conditional branch in EX.
- ex_is_jump  in  1  JAL/JALR in EX.
- ex_funct3  in  3  branch funct3.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_target  in  XLEN  computed taken target.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- ex_pred_target  in  XLEN  predicted target carried with this instruction.
- br_unsigned  out  1  to branch comparator; equals ex_funct3[1].
- br_less  in  1  from branch comparator.
- br_equal  in  1  from branch comparator.
- redirect_valid  out  1  registered one-cycle pulse: mispredict.
- redirect_pc  out  XLEN  correct next PC; valid with redirect_valid.

Behaviour:
- Reset (async):
  - redirect_valid=0, redirect_pc=0.
  - All table valid bits cleared.
  - All counters set to WNT (01).
  - The effect is immediate, including mid-redirect.
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Lookup: hit = valid[idx] & tag match.
  - pred_taken = hit & ctr[idx][1].
  - pred_target = tgt[idx].
  - No bypass: a same-cycle update to the same index is not visible until the next cycle.
- Resolve is active when ex_valid & ~ex_stall & ~redirect_valid. The EX instruction present in the redirect cycle is wrong-path and is ignored.
- Actual outcome by funct3:
  - 000 BEQ: taken = eq.
  - 001 BNE: taken = ~eq.
  - 100 BLT and 110 BLTU: taken = less.
  - 101 BGE and 111 BGEU: taken = ~less.
  - 010 and 011: treated as not-branch. No update, no redirect.
- Jump: always taken, regardless of br_less/br_equal.
- Mispredict = (taken != ex_pred_taken) | (taken & ex_pred_target != ex_target).
- On mispredict, the next cycle has:
  - redirect_valid=1.
  - redirect_pc = taken ? ex_target : ex_pc+4 (wraps modulo 2**XLEN).
- redirect_valid lasts exactly one cycle. Back-to-back redirects are impossible because of the squash rule above.
- Update, on resolve of a branch or jump, at the clock edge:
  - Branch that hits: counter saturates up if taken, down if not. SNT=00 and ST=11 saturate.
  - Branch that misses:
    - Taken: allocate the entry (valid=1, tag, tgt=ex_target, ctr=WT).
    - Not taken: no allocation.
  - Jump: allocate or overwrite with ctr=ST, tgt=ex_target.
  - Taken hit with a changed target: tgt is overwritten.
- A stall holds the current state; no double update occurs.

Optional Feature:
- Macro BRPRED_PERF_EN.
- When defined:
  - Adds outputs perf_br_cnt[31:0] and perf_misp_cnt[31:0].
  - perf_br_cnt increments on each resolved branch or jump.
  - perf_misp_cnt increments on each mispredict.
  - Both wrap at 2**32 and reset to 0.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Package br_pkg holds:
  - funct3 localparams (F3_BEQ … F3_BGEU).
  - 2-bit counter enum (SNT, WNT, WT, ST).
  - Saturating-update function.
- Sub-module brpred_table: valid/tag/target/counter storage.
  - One combinational read port (fetch).
  - One synchronous write port (EX update).
  - Async reset of valid bits and counters.

Test Plan:
- Reset, then if_pc=0x100 → pred_taken=0. Assert rst mid-redirect → redirect_valid drops immediately.
- BEQ at 0x100, br_equal=1, ex_target=0x140, ex_pred_taken=0:
  - Next cycle redirect_valid=1, redirect_pc=0x140.
  - Lookup of 0x100 then gives pred_taken=1, pred_target=0x140.
- BGEU funct3=111 → br_unsigned=1. br_less=1, ex_pred_taken=1 → redirect_pc=ex_pc+4, counter WT→WNT.
- Train BNE at 0x200 taken 3 times → ST. One not-taken → WT; pred_taken remains 1.
- JAL at 0x300 predicted taken with ex_pred_target=0x400, actual target 0x404 → redirect to 0x404, tgt updated.
- Mispredict followed by a valid EX op in the redirect cycle → that op is ignored (no update, no second redirect). funct3=010 → no update or redirect. ex_stall=1 → no update or redirect.

Source files
------------

// File: rtl/br_pkg.sv
// Shared branch-unit definitions: funct3 encodings, 2-bit counter states and
// the saturating counter update used by the predictor table.
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_update(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = ctr_e'(cur + 2'd1);
    end else begin
      if (cur != SNT) nxt = ctr_e'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/br_resolve_pred_if.sv
// Fetch/EX bundle for br_resolve_pred. Optional perf counters appear only
// when BRPRED_PERF_EN is defined.
interface br_resolve_pred_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic            ex_stall;
  logic            ex_is_branch;
  logic            ex_is_jump;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            br_unsigned;
  logic            br_less;
  logic            br_equal;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
`ifdef BRPRED_PERF_EN
  logic [31:0]     perf_br_cnt;
  logic [31:0]     perf_misp_cnt;
`endif

  modport master (
    output if_pc, ex_valid, ex_stall, ex_is_branch, ex_is_jump, ex_funct3,
           ex_pc, ex_target, ex_pred_taken, ex_pred_target, br_less, br_equal,
    input  pred_taken, pred_target, br_unsigned, redirect_valid, redirect_pc
`ifdef BRPRED_PERF_EN
           , perf_br_cnt, perf_misp_cnt
`endif
  );

  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_is_branch, ex_is_jump, ex_funct3,
           ex_pc, ex_target, ex_pred_taken, ex_pred_target, br_less, br_equal,
    output pred_taken, pred_target, br_unsigned, redirect_valid, redirect_pc
`ifdef BRPRED_PERF_EN
           , perf_br_cnt, perf_misp_cnt
`endif
  );

endinterface

// File: rtl/brpred_table.sv
// Direction/target storage: one combinational fetch read port and one
// synchronous EX update port that applies the training rules internally.
module brpred_table
  import br_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IDX_W-1:0]         rd_idx,
  input  logic [XLEN-IDX_W-3:0]    rd_tag,
  output logic                     rd_taken,
  output logic [XLEN-1:0]          rd_tgt,
  input  logic                     wr_en,
  input  logic                     wr_jump,
  input  logic                     wr_taken,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [XLEN-IDX_W-3:0]    wr_tag,
  input  logic [XLEN-1:0]          wr_tgt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [TAG_W-1:0] tag_d   [DEPTH];
  logic [XLEN-1:0]  tgt_q   [DEPTH];
  logic [XLEN-1:0]  tgt_d   [DEPTH];
  ctr_e             ctr_q   [DEPTH];
  ctr_e             ctr_d   [DEPTH];

  logic [1:0] rd_ctr;
  logic       wr_hit;

  always_comb begin
    rd_ctr   = ctr_q[rd_idx];
    rd_taken = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && rd_ctr[1];
    rd_tgt   = tgt_q[rd_idx];
  end

  // Jumps and taken misses (re)allocate; hits train the counter and refresh
  // the target when taken; not-taken misses leave the table alone.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    wr_hit  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    if (wr_en) begin
      if (wr_jump || (!wr_hit && wr_taken)) begin
        valid_d[wr_idx] = 1'b1;
        tag_d[wr_idx]   = wr_tag;
        tgt_d[wr_idx]   = wr_tgt;
        ctr_d[wr_idx]   = wr_jump ? ST : WT;
      end else if (wr_hit) begin
        ctr_d[wr_idx] = ctr_update(ctr_q[wr_idx], wr_taken);
        if (wr_taken) tgt_d[wr_idx] = wr_tgt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: rtl/br_resolve_pred.sv
// Branch predict/resolve unit: fetch lookup, EX outcome/mispredict detection
// and a registered redirect pulse. Define BRPRED_PERF_EN for perf counters.
module br_resolve_pred
  import br_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int XLEN  = 32
) (
  input  logic               clk,
  input  logic               rst,
  br_resolve_pred_if.slave   bus
);

  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            f3_ok, br_taken, taken, resolve, upd_en, mispredict;

  always_comb begin
    f3_ok    = 1'b1;
    br_taken = 1'b0;
    case (bus.ex_funct3)
      F3_BEQ:           br_taken = bus.br_equal;
      F3_BNE:           br_taken = ~bus.br_equal;
      F3_BLT, F3_BLTU:  br_taken = bus.br_less;
      F3_BGE, F3_BGEU:  br_taken = ~bus.br_less;
      default:          f3_ok    = 1'b0;
    endcase
  end

  // The instruction sitting in EX during a redirect is wrong-path.
  always_comb begin
    resolve          = bus.ex_valid & ~bus.ex_stall & ~redirect_valid_q;
    upd_en           = resolve & (bus.ex_is_jump | (bus.ex_is_branch & f3_ok));
    taken            = bus.ex_is_jump | br_taken;
    mispredict       = (taken != bus.ex_pred_taken) |
                       (taken & (bus.ex_pred_target != bus.ex_target));
    redirect_valid_d = upd_en & mispredict;
    redirect_pc_d    = redirect_pc_q;
    if (redirect_valid_d)
      redirect_pc_d = taken ? bus.ex_target
                            : bus.ex_pc + {{(XLEN-3){1'b0}}, 3'd4};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.br_unsigned    = bus.ex_funct3[1];

  brpred_table #(
    .IDX_W (IDX_W),
    .XLEN  (XLEN)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bus.if_pc[IDX_W+1:2]),
    .rd_tag   (bus.if_pc[XLEN-1:IDX_W+2]),
    .rd_taken (bus.pred_taken),
    .rd_tgt   (bus.pred_target),
    .wr_en    (upd_en),
    .wr_jump  (bus.ex_is_jump),
    .wr_taken (taken),
    .wr_idx   (bus.ex_pc[IDX_W+1:2]),
    .wr_tag   (bus.ex_pc[XLEN-1:IDX_W+2]),
    .wr_tgt   (bus.ex_target)
  );

`ifdef BRPRED_PERF_EN
  logic [31:0] perf_br_cnt_q, perf_br_cnt_d;
  logic [31:0] perf_misp_cnt_q, perf_misp_cnt_d;

  always_comb begin
    perf_br_cnt_d   = perf_br_cnt_q + {31'd0, upd_en};
    perf_misp_cnt_d = perf_misp_cnt_q + {31'd0, redirect_valid_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_cnt_q   <= '0;
      perf_misp_cnt_q <= '0;
    end else begin
      perf_br_cnt_q   <= perf_br_cnt_d;
      perf_misp_cnt_q <= perf_misp_cnt_d;
    end
  end

  assign bus.perf_br_cnt   = perf_br_cnt_q;
  assign bus.perf_misp_cnt = perf_misp_cnt_q;
`endif

endmodule
